oam_dma_controller: RTL and testbench
=====================================

Name: oam_dma_controller

Overview:
- Sequences GBC OAM DMA and arbitrates the single memory-router bus between the CPU and the DMA engine.
- Sits between the cpu core and memory_router, and owns register FF46 (DMA).
- A CPU write to FF46 copies XFER_LEN bytes from {FF46, 8'h00} to OAM_BASE.
- During the copy, CPU bus access is restricted to HRAM.

Parameters:
DMA_REG_ADDR, 16'hFF46, address of DMA source register
OAM_BASE, 16'hFE00, destination base address
XFER_LEN, 160, bytes per transfer (index width 8 bits)
START_DELAY, 1, idle cycles between FF46 write and first DMA read

Ports:
- cpu_clock  in  1  system clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- I_CPU_ADDR  in  16  CPU address
- I_CPU_WDATA  in  8  CPU write data
- O_CPU_RDATA  out  8  read data returned to CPU
- I_CPU_WE_L  in  1  CPU write strobe, active-low
- I_CPU_RE_L  in  1  CPU read strobe, active-low
- O_MEM_ADDR  out  16  address to memory_router
- O_MEM_WDATA  out  8  write data to memory_router
- I_MEM_RDATA  in  8  read data from memory_router, valid in the same cycle as RE_L low
- O_MEM_WE_L  out  1  write strobe to router
- O_MEM_RE_L  out  1  read strobe to router
- O_DMA_ACTIVE  out  1  high from FF46 write acceptance until the last OAM write completes

Behaviour:
Interface:
- Clock is cpu_clock; reset is reset, synchronous, active-high.
- Reset takes priority over all other events.

Reset values:
- dma_reg=8'h00, state=IDLE, idx=0, latch=8'h00, O_DMA_ACTIVE=0.
- While reset is high: O_MEM_WE_L=1, O_MEM_RE_L=1, O_CPU_RDATA=8'hFF.

Register FF46:
- A CPU write (WE_L=0, addr==DMA_REG_ADDR) loads dma_reg and is not forwarded to the router.
- A CPU read returns dma_reg combinationally, in every state.
- Source high byte: src_hi = dma_reg when dma_reg<8'hE0, otherwise dma_reg-8'h20 (echo RAM maps to WRAM).

States:
- IDLE: CPU passes through combinationally (addr, wdata, strobes to router; I_MEM_RDATA to O_CPU_RDATA). An FF46 write -> DELAY with cnt=START_DELAY-1, or -> RD if START_DELAY=0.
- DELAY: O_DMA_ACTIVE=1. CPU is already restricted. Decrement cnt; -> RD when cnt==0.
- RD: O_MEM_ADDR={src_hi, idx}, RE_L=0, WE_L=1. Capture I_MEM_RDATA into latch at the clock edge. -> WR.
- WR: O_MEM_ADDR=OAM_BASE+idx, WDATA=latch, WE_L=0, RE_L=1.
  - If idx==XFER_LEN-1: -> IDLE, idx=0, O_DMA_ACTIVE drops on that edge.
  - Otherwise: idx+1, -> RD.
- Nominal transfer: START_DELAY + 2*XFER_LEN cycles (321 at defaults).

CPU during DMA (any state except IDLE):
- HRAM (FF80-FFFE) accesses pass through to the router. A pass-through cycle steals the bus: DMA holds state, idx and latch that cycle and resumes next cycle.
- FF46 access follows the rules above.
- All other reads return 8'hFF; all other writes are dropped (router strobes stay high).
- Cycles with both CPU strobes high never stall DMA.

Simultaneous and boundary events:
- FF46 write during DMA: reload dma_reg, idx=0, -> DELAY (restart). A partial OAM copy is not rolled back.
- CPU strobes both low is illegal. Treat it as a read and flag it in simulation with an $error.
- idx never exceeds XFER_LEN-1; OAM_BASE+idx never exceeds FE9F.

Test Plan:
1. Reset mid-transfer at idx=50 -> next cycle state=IDLE, O_DMA_ACTIVE=0, router strobes=1, FF46 reads 8'h00.
2. CPU writes FF46=8'hC1 with WRAM C100+i=i -> exactly 160 router writes FE00+i=i; O_DMA_ACTIVE high 321 cycles; FF46 reads 8'hC1.
3. During DMA, CPU reads 8000 -> 8'hFF; writes C000 -> no router WE. CPU writes FF90=8'h5A then reads FF90 -> 8'h5A. Each HRAM access extends the transfer by 1 cycle, and OAM contents are still correct.
4. FF46=8'hE2 -> source reads come from C200-C29F.
5. FF46 rewritten with 8'hD0 at idx=80 -> idx restarts at 0; FE00-FE9F end holding D000-D09F data; total active time = 80*2+1 (+1 write cycle) +321.
6. Back-to-back transfers: second FF46 write the cycle after O_DMA_ACTIVE falls -> second transfer starts cleanly with no lost or duplicated OAM write.

Source files
------------

// File: rtl/oam_dma_controller.sv
// OAM DMA sequencer and CPU/DMA arbiter for the memory-router bus.
// Ports: cpu_clock/reset, CPU bus (I_CPU_*/O_CPU_RDATA), router bus (O_MEM_*/I_MEM_RDATA), O_DMA_ACTIVE.
module oam_dma_controller #(
  parameter logic [15:0] DMA_REG_ADDR = 16'hFF46,
  parameter logic [15:0] OAM_BASE     = 16'hFE00,
  parameter int unsigned XFER_LEN     = 160,
  parameter int unsigned START_DELAY  = 1
) (
  input  logic        cpu_clock,
  input  logic        reset,
  input  logic [15:0] I_CPU_ADDR,
  input  logic [7:0]  I_CPU_WDATA,
  output logic [7:0]  O_CPU_RDATA,
  input  logic        I_CPU_WE_L,
  input  logic        I_CPU_RE_L,
  output logic [15:0] O_MEM_ADDR,
  output logic [7:0]  O_MEM_WDATA,
  input  logic [7:0]  I_MEM_RDATA,
  output logic        O_MEM_WE_L,
  output logic        O_MEM_RE_L,
  output logic        O_DMA_ACTIVE
);

  typedef enum logic [1:0] {
    IDLE, DELAY, RD, WR
  } state_e;

  localparam logic [7:0] LAST = 8'(XFER_LEN - 1);
  localparam logic [7:0] CNT0 = 8'(START_DELAY - 1);
  localparam state_e START_ST =
    (START_DELAY == 0) ? RD : DELAY;

  state_e     state_q, state_d;
  logic [7:0] dma_q, dma_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] latch_q, latch_d;
  logic [7:0] cnt_q, cnt_d;

  logic       cpu_rd, cpu_wr;
  logic       hit_reg, hit_hram;
  logic       reg_wr, busy, steal, pass;
  logic [7:0] src_hi;

  // Both strobes low is resolved as a read.
  assign cpu_rd   = ~I_CPU_RE_L;
  assign cpu_wr   = ~I_CPU_WE_L & I_CPU_RE_L;
  assign hit_reg  = (I_CPU_ADDR == DMA_REG_ADDR);
  assign hit_hram = (I_CPU_ADDR >= 16'hFF80) &&
                    (I_CPU_ADDR != 16'hFFFF);
  assign reg_wr   = cpu_wr & hit_reg;
  assign busy     = (state_q != IDLE);
  // HRAM traffic during DMA owns the bus; DMA freezes.
  assign steal    = busy & (cpu_rd | cpu_wr) & hit_hram;
  assign pass     = ~busy | steal;
  // Echo RAM (E000+) aliases WRAM.
  assign src_hi   = (dma_q < 8'hE0) ? dma_q
                                    : dma_q - 8'h20;

  assign O_DMA_ACTIVE = busy;

  always_ff @(posedge cpu_clock) begin
    if (reset) begin
      state_q <= IDLE;
      dma_q   <= 8'h00;
      idx_q   <= 8'h00;
      latch_q <= 8'h00;
      cnt_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      dma_q   <= dma_d;
      idx_q   <= idx_d;
      latch_q <= latch_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dma_d   = dma_q;
    idx_d   = idx_q;
    latch_d = latch_q;
    cnt_d   = cnt_q;
    if (reg_wr) begin
      dma_d   = I_CPU_WDATA;
      idx_d   = 8'h00;
      cnt_d   = CNT0;
      state_d = START_ST;
    end else if (!steal) begin
      unique case (state_q)
        IDLE: ;
        DELAY: begin
          if (cnt_q == 8'h00) state_d = RD;
          else cnt_d = cnt_q - 8'h01;
        end
        RD: begin
          latch_d = I_MEM_RDATA;
          state_d = WR;
        end
        WR: begin
          if (idx_q == LAST) begin
            idx_d   = 8'h00;
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + 8'h01;
            state_d = RD;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    O_MEM_ADDR  = I_CPU_ADDR;
    O_MEM_WDATA = I_CPU_WDATA;
    O_MEM_WE_L  = 1'b1;
    O_MEM_RE_L  = 1'b1;
    O_CPU_RDATA = 8'hFF;
    if (!reset) begin
      if (hit_reg)   O_CPU_RDATA = dma_q;
      else if (pass) O_CPU_RDATA = I_MEM_RDATA;
      if (pass && !hit_reg) begin
        O_MEM_WE_L = ~cpu_wr;
        O_MEM_RE_L = ~cpu_rd;
      end else if (state_q == RD) begin
        O_MEM_ADDR = {src_hi, idx_q};
        O_MEM_RE_L = 1'b0;
      end else if (state_q == WR) begin
        O_MEM_ADDR  = OAM_BASE + {8'h00, idx_q};
        O_MEM_WDATA = latch_q;
        O_MEM_WE_L  = 1'b0;
      end
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge cpu_clock) begin
    if (!reset)
      assert (!(!I_CPU_WE_L && !I_CPU_RE_L))
        else $error("CPU strobes both low");
  end
`endif

endmodule

// File: tb/tb_oam_dma_controller.sv
// Directed bench for oam_dma_controller.
// Router memory model plus OAM write scoreboard.
module tb_oam_dma_controller;

  logic        cpu_clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] cpu_addr = 16'h0000;
  logic [7:0]  cpu_wdata = 8'h00;
  logic        cpu_we_l = 1'b1;
  logic        cpu_re_l = 1'b1;
  logic [7:0]  cpu_rdata;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_we_l, mem_re_l;
  logic        dma_active;

  logic [7:0] mem [0:65535];

  typedef struct packed {
    logic [15:0] a;
    logic [7:0]  d;
  } wr_t;
  wr_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int act_cnt = 0;

  always #5 cpu_clock = ~cpu_clock;

  assign mem_rdata = mem[mem_addr];

  oam_dma_controller dut (
    .cpu_clock    (cpu_clock),
    .reset        (reset),
    .I_CPU_ADDR   (cpu_addr),
    .I_CPU_WDATA  (cpu_wdata),
    .O_CPU_RDATA  (cpu_rdata),
    .I_CPU_WE_L   (cpu_we_l),
    .I_CPU_RE_L   (cpu_re_l),
    .O_MEM_ADDR   (mem_addr),
    .O_MEM_WDATA  (mem_wdata),
    .I_MEM_RDATA  (mem_rdata),
    .O_MEM_WE_L   (mem_we_l),
    .O_MEM_RE_L   (mem_re_l),
    .O_DMA_ACTIVE (dma_active)
  );

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  // Router model: memory, OAM scoreboard, active counter.
  initial begin
    wr_t e;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h33;
    for (int i = 0; i < 160; i++) begin
      mem[16'hC100 + i] = 8'(i);
      mem[16'hC200 + i] = 8'(i) ^ 8'hA5;
      mem[16'hD000 + i] = 8'(8'h80 + i);
    end
    forever begin
      @(negedge cpu_clock);
      #3;
      if (dma_active === 1'b1) act_cnt++;
      if (mem_we_l === 1'b0) begin
        if (mem_addr >= 16'hFE00 &&
            mem_addr <= 16'hFE9F) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL oam_unexp observed=%h/%h expected=none",
                   mem_addr, mem_wdata);
          end else begin
            e = exp_q.pop_front();
            chk("oam_addr", mem_addr, e.a);
            chk("oam_data", {8'h00, mem_wdata},
                {8'h00, e.d});
          end
        end
        mem[mem_addr] = mem_wdata;
      end
    end
  end

  task automatic push(input logic [7:0] hi,
                      input int n);
    wr_t e;
    for (int i = 0; i < n; i++) begin
      e.a = 16'(16'hFE00 + i);
      e.d = mem[{hi, 8'(i)}];
      exp_q.push_back(e);
    end
  endtask

  // Tasks start and end just after a negedge.
  task automatic cpu_write(input logic [15:0] a,
                           input logic [7:0] d);
    cpu_addr  = a;
    cpu_wdata = d;
    cpu_we_l  = 1'b0;
    @(posedge cpu_clock);
    #1 cpu_we_l = 1'b1;
    @(negedge cpu_clock);
  endtask

  task automatic cpu_read(input logic [15:0] a,
                          input logic [7:0] exp,
                          input string tag);
    cpu_addr = a;
    cpu_re_l = 1'b0;
    #1 chk(tag, {8'h00, cpu_rdata}, {8'h00, exp});
    @(posedge cpu_clock);
    #1 cpu_re_l = 1'b1;
    @(negedge cpu_clock);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (dma_active === 1'b1 && n < 2000) begin
      @(negedge cpu_clock);
      n++;
    end
    chk(tag, {15'h0, n < 2000}, 16'h0001);
  endtask

  task automatic wait_rd(input logic [15:0] a,
                         input string tag);
    int n = 0;
    while (!(mem_re_l === 1'b0 && mem_addr === a) &&
           n < 2000) begin
      @(negedge cpu_clock);
      n++;
    end
    chk(tag, {15'h0, n < 2000}, 16'h0001);
  endtask

  initial begin
    int a0;
    int bad;

    repeat (2) @(posedge cpu_clock);
    @(negedge cpu_clock);
    #1;
    chk("rst_we", {15'h0, mem_we_l}, 16'h0001);
    chk("rst_re", {15'h0, mem_re_l}, 16'h0001);
    chk("rst_rdata", {8'h00, cpu_rdata}, 16'h00FF);
    chk("rst_active", {15'h0, dma_active}, 16'h0000);
    reset = 1'b0;
    @(negedge cpu_clock);
    cpu_read(16'hFF46, 8'h00, "ff46_init");

    // Basic transfer from C100.
    push(8'hC1, 160);
    a0 = act_cnt;
    cpu_write(16'hFF46, 8'hC1);
    wait_idle("t2_timeout");
    chk("t2_len", 16'(act_cnt - a0), 16'd321);
    chk("t2_q", 16'(exp_q.size()), 16'd0);
    cpu_read(16'hFF46, 8'hC1, "t2_ff46");
    bad = 0;
    for (int i = 0; i < 160; i++)
      if (mem[16'hFE00 + i] !== 8'(i)) bad++;
    chk("t2_oam", 16'(bad), 16'd0);

    // CPU restrictions and HRAM stealing.
    push(8'hC1, 160);
    a0 = act_cnt;
    cpu_write(16'hFF46, 8'hC1);
    cpu_read(16'h8000, 8'hFF, "t3_rd_blocked");
    cpu_addr  = 16'hC000;
    cpu_wdata = 8'h77;
    cpu_we_l  = 1'b0;
    #1 chk("t3_wr_drop",
           {15'h0, (mem_we_l === 1'b0 &&
                    mem_addr === 16'hC000)}, 16'h0000);
    @(posedge cpu_clock);
    #1 cpu_we_l = 1'b1;
    @(negedge cpu_clock);
    cpu_write(16'hFF90, 8'h5A);
    cpu_read(16'hFF90, 8'h5A, "t3_hram");
    wait_idle("t3_timeout");
    chk("t3_len", 16'(act_cnt - a0), 16'd323);
    chk("t3_q", 16'(exp_q.size()), 16'd0);
    chk("t3_c000", {8'h00, mem[16'hC000]}, 16'h0033);

    // Echo source E2 -> C2.
    push(8'hC2, 160);
    a0 = act_cnt;
    cpu_write(16'hFF46, 8'hE2);
    wait_idle("t4_timeout");
    chk("t4_len", 16'(act_cnt - a0), 16'd321);
    chk("t4_q", 16'(exp_q.size()), 16'd0);
    cpu_read(16'hFF46, 8'hE2, "t4_ff46");

    // Restart with D0 during the read of idx 80.
    push(8'hC1, 80);
    push(8'hD0, 160);
    a0 = act_cnt;
    cpu_write(16'hFF46, 8'hC1);
    wait_rd(16'hC150, "t5_wait");
    cpu_write(16'hFF46, 8'hD0);
    wait_idle("t5_timeout");
    chk("t5_len", 16'(act_cnt - a0), 16'd483);
    chk("t5_q", 16'(exp_q.size()), 16'd0);
    bad = 0;
    for (int i = 0; i < 160; i++)
      if (mem[16'hFE00 + i] !== 8'(8'h80 + i)) bad++;
    chk("t5_oam", 16'(bad), 16'd0);

    // Back-to-back transfers.
    push(8'hC1, 160);
    push(8'hC2, 160);
    a0 = act_cnt;
    cpu_write(16'hFF46, 8'hC1);
    wait_idle("t6a_timeout");
    cpu_write(16'hFF46, 8'hC2);
    wait_idle("t6b_timeout");
    chk("t6_len", 16'(act_cnt - a0), 16'd642);
    chk("t6_q", 16'(exp_q.size()), 16'd0);

    // Reset mid-transfer at idx 50.
    push(8'hC1, 50);
    cpu_write(16'hFF46, 8'hC1);
    wait_rd(16'hC132, "t1_wait");
    reset    = 1'b1;
    cpu_addr = 16'hFF90;
    cpu_re_l = 1'b0;
    #1;
    chk("t1_rst_we", {15'h0, mem_we_l}, 16'h0001);
    chk("t1_rst_re", {15'h0, mem_re_l}, 16'h0001);
    chk("t1_rst_rdata", {8'h00, cpu_rdata}, 16'h00FF);
    @(posedge cpu_clock);
    #1;
    reset    = 1'b0;
    cpu_re_l = 1'b1;
    #1;
    chk("t1_active", {15'h0, dma_active}, 16'h0000);
    chk("t1_we", {15'h0, mem_we_l}, 16'h0001);
    chk("t1_re", {15'h0, mem_re_l}, 16'h0001);
    @(negedge cpu_clock);
    cpu_read(16'hFF46, 8'h00, "t1_ff46");
    repeat (4) @(negedge cpu_clock);
    chk("t1_q", 16'(exp_q.size()), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
